bids_round_sequencer: RTL

//  Host-side initiator for the BIDS22 bid controller's C_* control port.

---
 rtl/bids_pkg.sv | 50 +++++
 rtl/bids_watchdog.sv | 32 +++
 rtl/bids_round_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bids_pkg.sv
// Shared types for the BIDS22 round sequencer: controller opcodes, error codes,
// response status values and the sequencer state encoding.
package bids_pkg;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_UNLOCK    = 4'd1,
    OP_LOCK      = 4'd2,
    OP_LOADX     = 4'd3,
    OP_LOADY     = 4'd4,
    OP_LOADZ     = 4'd5,
    OP_SETMASK   = 4'd6,
    OP_SETTIMER  = 4'd7,
    OP_BIDCHARGE = 4'd8
  } op_e;

  // Any nonzero controller err is a failure; only the "no error" value is named.
  localparam logic [2:0] ERR_NONE = 3'd0;

  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_CFG_ERR    = 3'd1,
    ST_LOCK_ERR   = 3'd2,
    ST_UNLOCK_ERR = 3'd3,
    ST_TIMEOUT    = 3'd4
  } status_e;

  typedef enum logic [3:0] {
    S_WAIT_RDY = 4'd0,
    S_IDLE     = 4'd1,
    S_LDX      = 4'd2,
    S_LDY      = 4'd3,
    S_LDZ      = 4'd4,
    S_MASK     = 4'd5,
    S_TIMER    = 4'd6,
    S_COST     = 4'd7,
    S_LOCK     = 4'd8,
    S_START    = 4'd9,
    S_DRAIN    = 4'd10,
    S_RESULT   = 4'd11,
    S_DONE     = 4'd12
  } state_e;

  // States whose err sample can abort the request.
  function automatic logic is_abortable(input state_e s);
    return (s == S_LDX) || (s == S_LDY) || (s == S_LDZ) || (s == S_MASK) ||
           (s == S_TIMER) || (s == S_COST) || (s == S_LOCK);
  endfunction

endpackage

// File: rtl/bids_watchdog.sv
// Loadable down-counter. o_expire is high during the last counted cycle, so a
// load of N marks the Nth cycle after the start edge.
module bids_watchdog #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_start,
  input  logic         i_clear,
  input  logic [W-1:0] i_load,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;
  logic         r_active;

  always_ff @(posedge clk) begin
    if (!reset_n || i_clear) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= i_load;
      r_active <= (i_load != '0);
    end else if (r_active) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == W'(1)) r_active <= 1'b0;
    end
  end

  assign o_expire = r_active && (r_cnt == W'(1));

endmodule

// File: rtl/bids_round_sequencer.sv
// Host-side initiator for the BIDS22 controller port: configures, locks, runs
// one round, collects the result and unlocks, then reports on a response port.
module bids_round_sequencer
  import bids_pkg::*;
#(
  parameter int WD_CYCLES = 64,
  parameter int RLEN_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_x_init,
  input  logic [31:0]       req_y_init,
  input  logic [31:0]       req_z_init,
  input  logic [2:0]        req_mask,
  input  logic [3:0]        req_timer,
  input  logic [31:0]       req_bid_cost,
  input  logic [31:0]       req_key,
  input  logic [RLEN_W-1:0] req_round_len,
  output logic [3:0]        C_op,
  output logic [31:0]       C_data,
  output logic              C_start,
  input  logic              ready,
  input  logic [2:0]        err,
  input  logic              roundOver,
  input  logic [31:0]       maxBid,
  input  logic              X_win,
  input  logic              Y_win,
  input  logic              Z_win,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [2:0]        resp_status,
  output logic [2:0]        resp_err,
  output logic [2:0]        resp_win,
  output logic [31:0]       resp_maxbid,
  output logic              resp_warn,
  output logic [3:0]        dbg_state
);

  localparam int WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_CYCLES[WD_W-1:0];

  state_e            r_state;
  logic [31:0]       r_y;
  logic [31:0]       r_z;
  logic [2:0]        r_mask;
  logic [3:0]        r_timer;
  logic [31:0]       r_cost;
  logic [31:0]       r_key;
  logic [RLEN_W-1:0] r_round_len;

  logic              w_op_err;
  logic [RLEN_W-1:0] w_rlen;
  logic              w_rnd_start;
  logic              w_rnd_expire;
  logic              w_wd_start;
  logic              w_wd_expire;
  logic              w_clear;

  assign w_op_err    = is_abortable(r_state) && (err != ERR_NONE);
  assign w_rlen      = (r_round_len == '0) ? RLEN_W'(1) : r_round_len;
  assign w_rnd_start = (r_state == S_LOCK) && !w_op_err;
  assign w_wd_start  = (r_state == S_DRAIN);
  assign w_clear     = (r_state == S_DONE);
  assign dbg_state   = r_state;

  bids_watchdog #(.W(RLEN_W)) u_round_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_rnd_start),
    .i_clear  (w_clear),
    .i_load   (w_rlen),
    .o_expire (w_rnd_expire)
  );

  bids_watchdog #(.W(WD_W)) u_result_wd (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_start  (w_wd_start),
    .i_clear  (w_clear),
    .i_load   (WD_LOAD),
    .o_expire (w_wd_expire)
  );

  // Both ports: a transfer happens on the rising edge where valid and ready are
  // both high; valid and its payload stay fixed until that edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_WAIT_RDY;
      r_y         <= '0;
      r_z         <= '0;
      r_mask      <= '0;
      r_timer     <= '0;
      r_cost      <= '0;
      r_key       <= '0;
      r_round_len <= '0;
      C_op        <= OP_NOP;
      C_data      <= '0;
      C_start     <= 1'b0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_status <= ST_OK;
      resp_err    <= '0;
      resp_win    <= '0;
      resp_maxbid <= '0;
      resp_warn   <= 1'b0;
    end else if (w_op_err) begin
      r_state     <= S_DONE;
      C_op        <= OP_NOP;
      C_data      <= '0;
      resp_valid  <= 1'b1;
      resp_status <= (r_state == S_LOCK) ? ST_LOCK_ERR : ST_CFG_ERR;
      resp_err    <= err;
      resp_win    <= '0;
      resp_maxbid <= '0;
    end else begin
      case (r_state)
        S_WAIT_RDY: begin
          if (ready) begin
            r_state   <= S_IDLE;
            req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_y         <= req_y_init;
            r_z         <= req_z_init;
            r_mask      <= req_mask;
            r_timer     <= req_timer;
            r_cost      <= req_bid_cost;
            r_key       <= req_key;
            r_round_len <= req_round_len;
            req_ready   <= 1'b0;
            resp_warn   <= 1'b0;
            r_state     <= S_LDX;
            C_op        <= OP_LOADX;
            C_data      <= req_x_init;
          end
        end
        S_LDX: begin
          r_state <= S_LDY;
          C_op    <= OP_LOADY;
          C_data  <= r_y;
        end
        S_LDY: begin
          r_state <= S_LDZ;
          C_op    <= OP_LOADZ;
          C_data  <= r_z;
        end
        S_LDZ: begin
          r_state <= S_MASK;
          C_op    <= OP_SETMASK;
          C_data  <= {29'b0, r_mask};
        end
        S_MASK: begin
          r_state <= S_TIMER;
          C_op    <= OP_SETTIMER;
          C_data  <= {28'b0, r_timer};
        end
        S_TIMER: begin
          r_state <= S_COST;
          C_op    <= OP_BIDCHARGE;
          C_data  <= r_cost;
        end
        S_COST: begin
          r_state <= S_LOCK;
          C_op    <= OP_LOCK;
          C_data  <= r_key;
        end
        S_LOCK: begin
          r_state <= S_START;
          C_op    <= OP_NOP;
          C_data  <= '0;
          C_start <= 1'b1;
        end
        S_START: begin
          // Errors while the round runs are only reported, never fatal.
          if (err != ERR_NONE) resp_warn <= 1'b1;
          if (w_rnd_expire) begin
            r_state <= S_DRAIN;
            C_start <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_state <= S_RESULT;
          C_op    <= OP_UNLOCK;
          C_data  <= r_key;
        end
        S_RESULT: begin
          if (roundOver) begin
            r_state     <= S_DONE;
            C_op        <= OP_NOP;
            C_data      <= '0;
            resp_valid  <= 1'b1;
            resp_status <= (err == ERR_NONE) ? ST_OK : ST_UNLOCK_ERR;
            resp_err    <= err;
            resp_win    <= {X_win, Y_win, Z_win};
            resp_maxbid <= maxBid;
          end else if (w_wd_expire) begin
            r_state     <= S_DONE;
            C_op        <= OP_NOP;
            C_data      <= '0;
            resp_valid  <= 1'b1;
            resp_status <= ST_TIMEOUT;
            resp_err    <= '0;
            resp_win    <= '0;
            resp_maxbid <= '0;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            r_state    <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: r_state <= S_WAIT_RDY;
      endcase
    end
  end

endmodule
